// File: rtl/eth_stream_pkg.sv
// Shared widths, FSM state encoding and the beat record used by the egress arbiter.
package eth_stream_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;

  typedef enum logic {IDLE, LOCK} arb_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

endpackage

// File: rtl/eth_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N_SRC.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
module eth_rr_pick #(
  parameter int N_SRC = 4,
  parameter int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_SRC-1:0] pick,
  output logic             any
);

  logic [2*N_SRC-1:0] req_dbl;
  logic [2*N_SRC-1:0] pick_dbl;
  logic [N_SRC-1:0]   rot;
  logic [N_SRC-1:0]   rot_pick;

  // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_dbl  = {req, req} >> ptr;
    rot      = req_dbl[N_SRC-1:0];
    rot_pick = rot & (-rot);
    pick_dbl = {rot_pick, rot_pick} << ptr;
    pick     = pick_dbl[2*N_SRC-1:N_SRC];
    any      = |req;
  end

endmodule

// File: rtl/eth_stream_rr_arbiter.sv
// Packet-granular round-robin arbiter onto one 64-bit AXI-stream egress, with per-source frame counters.
// Latency: grant registered (one IDLE cycle between frames); data path is zero-cycle pass-through.
// Backpressure: stream_out_READY forwarded to the owner only; non-owners never see READY.
module eth_stream_rr_arbiter
  import eth_stream_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC*DATA_W-1:0]  src_DATA,
  input  logic [N_SRC*KEEP_W-1:0]  src_KEEP,
  input  logic [N_SRC-1:0]         src_LAST,
  input  logic [N_SRC-1:0]         src_VALID,
  output logic [N_SRC-1:0]         src_READY,
  output logic [DATA_W-1:0]        stream_out_DATA,
  output logic [KEEP_W-1:0]        stream_out_KEEP,
  output logic                     stream_out_LAST,
  output logic                     stream_out_VALID,
  input  logic                     stream_out_READY,
  output logic [N_SRC-1:0]         grant,
  output logic                     busy,
  output logic [N_SRC*CNT_W-1:0]   frame_cnt
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  arb_state_t       state_q, state_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner;
  logic [N_SRC-1:0] pick;
  logic             pick_any;
  logic [CNT_W-1:0] cnt_q [N_SRC];
  beat_t            owner_beat;
  logic             owner_vld;
  logic             fire_last;

  eth_rr_pick #(.N_SRC(N_SRC), .PTR_W(PTR_W)) u_pick (
    .req  (src_VALID),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (pick_any)
  );

  always_comb begin
    owner = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q[i]) owner = PTR_W'(i);
    end
  end

  always_comb begin
    owner_beat.data = src_DATA[owner*DATA_W +: DATA_W];
    owner_beat.keep = src_KEEP[owner*KEEP_W +: KEEP_W];
    owner_beat.last = src_LAST[owner];
    owner_vld       = src_VALID[owner];
  end

  assign fire_last = (state_q == LOCK) && owner_vld && stream_out_READY && owner_beat.last;

  // Egress is forced to zero whenever no owner beat is being offered.
  always_comb begin
    stream_out_DATA  = '0;
    stream_out_KEEP  = '0;
    stream_out_LAST  = 1'b0;
    stream_out_VALID = 1'b0;
    src_READY        = '0;
    if (state_q == LOCK) begin
      src_READY = grant_q & {N_SRC{stream_out_READY}};
      if (owner_vld) begin
        stream_out_DATA  = owner_beat.data;
        stream_out_KEEP  = owner_beat.keep;
        stream_out_LAST  = owner_beat.last;
        stream_out_VALID = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (fire_last) begin
          grant_d = '0;
          ptr_d   = (owner == PTR_W'(N_SRC-1)) ? '0 : owner + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      if (fire_last) cnt_q[owner] <= cnt_q[owner] + 1'b1;
    end
  end

  always_comb begin
    frame_cnt = '0;
    for (int i = 0; i < N_SRC; i++) frame_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign grant = grant_q;
  assign busy  = (state_q == LOCK);

endmodule

// File: tb/tb_eth_stream_rr_arbiter.sv
// Table-driven bench for eth_stream_rr_arbiter (4 sources, 4-bit counters) with an egress beat scoreboard.
module tb_eth_stream_rr_arbiter;

  localparam int N = 4;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N*64-1:0]  src_DATA = '0;
  logic [N*8-1:0]   src_KEEP = '0;
  logic [N-1:0]     src_LAST = '0;
  logic [N-1:0]     src_VALID = '0;
  logic [N-1:0]     src_READY;
  logic [63:0]      stream_out_DATA;
  logic [7:0]       stream_out_KEEP;
  logic             stream_out_LAST;
  logic             stream_out_VALID;
  logic             stream_out_READY = 1'b0;
  logic [N-1:0]     grant;
  logic             busy;
  logic [N*CW-1:0]  frame_cnt;

  eth_stream_rr_arbiter #(.N_SRC(N), .CNT_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .src_DATA         (src_DATA),
    .src_KEEP         (src_KEEP),
    .src_LAST         (src_LAST),
    .src_VALID        (src_VALID),
    .src_READY        (src_READY),
    .stream_out_DATA  (stream_out_DATA),
    .stream_out_KEEP  (stream_out_KEEP),
    .stream_out_LAST  (stream_out_LAST),
    .stream_out_VALID (stream_out_VALID),
    .stream_out_READY (stream_out_READY),
    .grant            (grant),
    .busy             (busy),
    .frame_cnt        (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          rst;
    logic [3:0]  vld;
    logic [3:0]  last;
    bit          ordy;
    logic [63:0] d;
    logic [7:0]  k;
    logic [3:0]  eg;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } exp_beat_t;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [CW-1:0] ec [N];
  exp_beat_t   sb [$];
  vec_t        tbl [$];

  localparam logic [63:0] D0 = 64'h0100000100030000;
  localparam logic [63:0] D1 = 64'h5073930200000000;

  function automatic vec_t mk(bit chk, bit rst, logic [3:0] vld, logic [3:0] last, bit ordy,
                              logic [63:0] d, logic [7:0] k, logic [3:0] eg);
    vec_t v;
    v.chk = chk; v.rst = rst; v.vld = vld; v.last = last; v.ordy = ordy;
    v.d = d; v.k = k; v.eg = eg;
    return v;
  endfunction

  function automatic logic [63:0] pat(int i);
    return 64'(i) * 64'h1111_1111_1111_1111;
  endfunction

  function automatic int own(logic [3:0] g);
    int o = 0;
    for (int i = 0; i < N; i++) if (g[i]) o = i;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    int        o;
    bit        eov;
    exp_beat_t eb;
    exp_beat_t got;
    @(posedge clk);
    #1;
    reset            = v.rst;
    src_VALID        = v.vld;
    src_LAST         = v.last;
    stream_out_READY = v.ordy;
    for (int i = 0; i < N; i++) begin
      src_DATA[64*i +: 64] = v.d ^ pat(i);
      src_KEEP[8*i +: 8]   = v.k ^ 8'(i);
    end
    @(negedge clk);
    o   = own(v.eg);
    eov = (v.eg != 4'b0) && v.vld[o];
    if (v.chk) begin
      chk("grant", 64'(grant), 64'(v.eg));
      chk("src_ready", 64'(src_READY), 64'(v.eg & {4{v.ordy}}));
      chk("busy", 64'(busy), 64'(v.eg != 4'b0));
      chk("out_valid", 64'(stream_out_VALID), 64'(eov));
      chk("out_last", 64'(stream_out_LAST), eov ? 64'(v.last[o]) : 64'd0);
      chk("out_data", stream_out_DATA, eov ? (v.d ^ pat(o)) : 64'd0);
      chk("out_keep", 64'(stream_out_KEEP), eov ? 64'(v.k ^ 8'(o)) : 64'd0);
      chk("frame_cnt", 64'(frame_cnt), 64'({ec[3], ec[2], ec[1], ec[0]}));
      if (eov && v.ordy) begin
        eb.data = v.d ^ pat(o);
        eb.keep = v.k ^ 8'(o);
        eb.last = v.last[o];
        sb.push_back(eb);
      end
    end
    if (stream_out_VALID && stream_out_READY) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_beat", 64'd1, 64'd0);
      end else begin
        got = sb.pop_front();
        chk("sb_data", stream_out_DATA, got.data);
        chk("sb_keep", 64'(stream_out_KEEP), 64'(got.keep));
        chk("sb_last", 64'(stream_out_LAST), 64'(got.last));
      end
    end
    if (v.rst) begin
      for (int i = 0; i < N; i++) ec[i] = '0;
    end else if (v.chk && eov && v.ordy && v.last[o]) begin
      ec[o] = ec[o] + 1'b1;
    end
  endtask

  task automatic do_reset();
    apply(mk(0, 1, 4'h0, 4'h0, 0, 64'd0, 8'h00, 4'h0));
    apply(mk(1, 1, 4'h0, 4'h0, 0, 64'd0, 8'h00, 4'h0));
  endtask

  initial begin
    for (int i = 0; i < N; i++) ec[i] = '0;

    // Tests 1, 3, 4 as one continuous table after reset.
    tbl.push_back(mk(1, 0, 4'b0001, 4'b0000, 1, D0, 8'hff, 4'b0000));
    tbl.push_back(mk(1, 0, 4'b0001, 4'b0000, 1, D0, 8'hff, 4'b0001));
    tbl.push_back(mk(1, 0, 4'b0001, 4'b0001, 1, D1, 8'h0f, 4'b0001));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 64'd0, 8'h00, 4'b0000));
    tbl.push_back(mk(1, 0, 4'b0011, 4'b0011, 1, 64'hAAAA_0000_0000_0001, 8'h3c, 4'b0000));
    tbl.push_back(mk(1, 0, 4'b0011, 4'b0011, 1, 64'hAAAA_0000_0000_0001, 8'h3c, 4'b0010));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 64'd0, 8'h00, 4'b0000));
    tbl.push_back(mk(1, 0, 4'b0010, 4'b0000, 1, 64'hB0B0_0000_0000_000A, 8'hff, 4'b0000));
    tbl.push_back(mk(1, 0, 4'b0110, 4'b0000, 1, 64'hB0B0_0000_0000_000A, 8'hff, 4'b0010));
    for (int c = 0; c < 5; c++)
      tbl.push_back(mk(1, 0, 4'b0110, 4'b0000, 0, 64'hB0B0_0000_0000_000B, 8'h7f, 4'b0010));
    tbl.push_back(mk(1, 0, 4'b0110, 4'b0000, 1, 64'hB0B0_0000_0000_000B, 8'h7f, 4'b0010));
    tbl.push_back(mk(1, 0, 4'b0110, 4'b0010, 1, 64'hB0B0_0000_0000_000C, 8'h01, 4'b0010));
    tbl.push_back(mk(1, 0, 4'b0100, 4'b0100, 1, 64'hC1C1_0000_0000_0001, 8'hf0, 4'b0000));
    tbl.push_back(mk(1, 0, 4'b0100, 4'b0100, 1, 64'hC1C1_0000_0000_0001, 8'hf0, 4'b0100));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 64'd0, 8'h00, 4'b0000));
    tbl.push_back(mk(1, 0, 4'b0100, 4'b0000, 1, 64'hD2D2_0000_0000_0001, 8'hff, 4'b0000));
    tbl.push_back(mk(1, 0, 4'b1100, 4'b0000, 1, 64'hD2D2_0000_0000_0001, 8'hff, 4'b0100));
    for (int c = 0; c < 3; c++)
      tbl.push_back(mk(1, 0, 4'b1000, 4'b0000, 1, 64'hD2D2_0000_0000_0002, 8'hff, 4'b0100));
    tbl.push_back(mk(1, 0, 4'b1100, 4'b0100, 1, 64'hD2D2_0000_0000_0002, 8'h03, 4'b0100));
    tbl.push_back(mk(1, 0, 4'b1000, 4'b1000, 1, 64'hE3E3_0000_0000_0001, 8'hff, 4'b0000));
    tbl.push_back(mk(1, 0, 4'b1000, 4'b1000, 1, 64'hE3E3_0000_0000_0001, 8'hff, 4'b1000));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 64'd0, 8'h00, 4'b0000));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Test 5: reset lands while src3 holds the grant mid-frame.
    apply(mk(1, 0, 4'b1000, 4'b0000, 1, 64'hF4F4_0000_0000_0001, 8'hff, 4'b0000));
    apply(mk(1, 0, 4'b1000, 4'b0000, 1, 64'hF4F4_0000_0000_0001, 8'hff, 4'b1000));
    apply(mk(1, 1, 4'b1000, 4'b0000, 0, 64'hF4F4_0000_0000_0002, 8'hff, 4'b1000));
    apply(mk(1, 0, 4'b1001, 4'b1001, 1, 64'h0505_0000_0000_0001, 8'hff, 4'b0000));
    apply(mk(1, 0, 4'b1001, 4'b1001, 1, 64'h0505_0000_0000_0001, 8'hff, 4'b0001));
    apply(mk(1, 0, 4'b1000, 4'b1000, 1, 64'h0505_0000_0000_0002, 8'hff, 4'b0000));
    apply(mk(1, 0, 4'b1000, 4'b1000, 1, 64'h0505_0000_0000_0002, 8'hff, 4'b1000));
    apply(mk(1, 0, 4'b0000, 4'b0000, 1, 64'd0, 8'h00, 4'b0000));

    // Test 2: all sources offer single-beat frames back to back.
    do_reset();
    for (int f = 0; f < 8; f++) begin
      apply(mk(1, 0, 4'hf, 4'hf, 1, {32'hC0DE0000, 32'(f)}, 8'hff, 4'b0000));
      apply(mk(1, 0, 4'hf, 4'hf, 1, {32'hC0DE0000, 32'(f)}, 8'hff, 4'(1 << (f % 4))));
    end
    apply(mk(1, 0, 4'h0, 4'h0, 1, 64'd0, 8'h00, 4'b0000));
    chk("rr_equal_counts", 64'(frame_cnt), 64'h2222);

    // Test 6: 17 frames from src0 wrap its 4-bit counter to 1.
    do_reset();
    for (int f = 0; f < 17; f++) begin
      apply(mk(1, 0, 4'b0001, 4'b0001, 1, {32'h6060_0000, 32'(f)}, 8'h81, 4'b0000));
      apply(mk(1, 0, 4'b0001, 4'b0001, 1, {32'h6060_0000, 32'(f)}, 8'h81, 4'b0001));
    end
    apply(mk(1, 0, 4'h0, 4'h0, 1, 64'd0, 8'h00, 4'b0000));
    chk("cnt_wrap", 64'(frame_cnt[CW-1:0]), 64'd1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
